// File: rtl/sata_fis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sata_fis_pkg
// Purpose  : Shared SATA FIS CRC constants, dword CRC step and TX state type.
// Revision : 1.0 - initial release
// ============================================================================
package sata_fis_pkg;

    localparam logic [31:0] SATA_CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] SATA_CRC_INIT   = 32'h52325032;
    localparam int          SATA_FIS_MAXLEN = 2048;

    typedef enum logic {ST_DATA, ST_CRC} fis_tx_state_t;

    // MSB-first, non-reflected, no final XOR; one full dword per call.
    function automatic logic [31:0] sata_crc32_dword(input logic [31:0] crc,
                                                     input logic [31:0] dat);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ dat[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ SATA_CRC_POLY;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sata_fis_crc32.sv
`default_nettype none
// ============================================================================
// Module   : sata_fis_crc32
// Purpose  : Combinational one-dword SATA CRC-32 step (shared by TX and RX).
// Revision : 1.0 - initial release
// ============================================================================
module sata_fis_crc32
    import sata_fis_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [31:0] i_dat,
    output logic [31:0] o_crc
);

    assign o_crc = sata_crc32_dword(i_crc, i_dat);

endmodule
`default_nettype wire

// File: rtl/sata_fis_crc_inserter.sv
`default_nettype none
// ============================================================================
// Module   : sata_fis_crc_inserter
// Purpose  : Appends the SATA CRC-32 dword to each transmitted FIS frame.
//            Optional length check enabled by macro SATA_FIS_LEN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sata_fis_crc_inserter
    import sata_fis_pkg::*;
#(
    parameter int          MAXLEN   = SATA_FIS_MAXLEN,
    parameter logic [31:0] CRC_INIT = SATA_CRC_INIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_dat,
    input  logic        i_eop,
    input  logic        i_val,
    output logic        i_rdy,
    output logic [31:0] o_dat,
    output logic        o_eop,
    output logic        o_val,
    input  logic        o_rdy,
    output logic        o_err
);

    fis_tx_state_t r_state, w_state_nxt;
    logic [31:0]   r_dat, w_dat_nxt;
    logic          r_eop, w_eop_nxt;
    logic          r_val, w_val_nxt;
    logic [31:0]   r_crc, w_crc_nxt;
    logic [31:0]   w_crc_step;
    logic          w_ld;
    logic          w_accept;
    logic          w_crc_emit;
    logic          w_len_hit;

    sata_fis_crc32 u_crc (
        .i_crc (r_crc),
        .i_dat (i_dat),
        .o_crc (w_crc_step)
    );

    assign w_ld = ~r_val | o_rdy;

    always_comb begin
        w_state_nxt = r_state;
        w_dat_nxt   = r_dat;
        w_eop_nxt   = r_eop;
        w_val_nxt   = r_val;
        w_crc_nxt   = r_crc;
        i_rdy       = 1'b0;
        w_accept    = 1'b0;
        w_crc_emit  = 1'b0;
        case (r_state)
            ST_DATA: begin
                i_rdy = w_ld;
                if (i_val && w_ld) begin
                    w_accept  = 1'b1;
                    w_dat_nxt = i_dat;
                    w_eop_nxt = 1'b0;
                    w_val_nxt = 1'b1;
                    w_crc_nxt = w_crc_step;
                    if (i_eop || w_len_hit) begin
                        w_state_nxt = ST_CRC;
                    end
                end else if (w_ld) begin
                    w_val_nxt = 1'b0;
                end
            end
            ST_CRC: begin
                if (w_ld) begin
                    w_crc_emit  = 1'b1;
                    w_dat_nxt   = r_crc;
                    w_eop_nxt   = 1'b1;
                    w_val_nxt   = 1'b1;
                    w_crc_nxt   = CRC_INIT;
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_DATA;
            r_dat   <= 32'h0;
            r_eop   <= 1'b0;
            r_val   <= 1'b0;
            r_crc   <= CRC_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_dat   <= w_dat_nxt;
            r_eop   <= w_eop_nxt;
            r_val   <= w_val_nxt;
            r_crc   <= w_crc_nxt;
        end
    end

`ifdef SATA_FIS_LEN_CHECK_EN
    localparam int                 CNT_W         = $clog2(MAXLEN + 1);
    localparam logic [CNT_W-1:0]   C_LAST_CNT    = CNT_W'(MAXLEN - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // The accepted word is the MAXLEN-th of the frame when cnt is one short.
    assign w_len_hit = (r_cnt == C_LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_crc_emit) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept && w_len_hit && !i_eop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign w_len_hit = 1'b0;

    // Without the length check only an illegal MAXLEN configuration can flag.
    if (MAXLEN >= 1 && MAXLEN <= SATA_FIS_MAXLEN) begin : g_no_len_check
        assign o_err = 1'b0;
    end else begin : g_bad_maxlen
        assign o_err = 1'b1;
    end
`endif

    assign o_dat = r_dat;
    assign o_eop = r_eop;
    assign o_val = r_val;

endmodule
`default_nettype wire

// File: tb/tb_sata_fis_crc_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sata_fis_crc_inserter
// Purpose  : Scoreboard bench for sata_fis_crc_inserter (data + CRC stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sata_fis_crc_inserter;

    localparam int          TB_MAXLEN = 4;
    localparam logic [31:0] TB_INIT   = 32'h52325032;
`ifdef SATA_FIS_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] dat;
        logic        eop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_dat;
    logic        i_eop;
    logic        i_val;
    logic        i_rdy;
    logic [31:0] o_dat;
    logic        o_eop;
    logic        o_val;
    logic        o_rdy;
    logic        o_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    logic [31:0] m_crc;
    int          m_cnt;
    bit          m_err;
    bit          m_pending;
    bit          rdy_rand = 1'b0;

    sata_fis_crc_inserter #(.MAXLEN(TB_MAXLEN), .CRC_INIT(TB_INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .i_dat (i_dat),
        .i_eop (i_eop),
        .i_val (i_val),
        .i_rdy (i_rdy),
        .o_dat (o_dat),
        .o_eop (o_eop),
        .o_val (o_val),
        .o_rdy (o_rdy),
        .o_err (o_err)
    );

    always #5 clk = ~clk;

    // Reference CRC: fold the dword in first, then 32 polynomial shifts.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int k = 0; k < 32; k++) begin
            r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_crc     = TB_INIT;
        m_cnt     = 0;
        m_err     = 1'b0;
        m_pending = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word was taken.
    task automatic send_word(input logic [31:0] d, input logic e, input bit chk_wait);
        int  n;
        bit  closes;
        n     = 0;
        i_dat = d;
        i_eop = e;
        i_val = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!i_rdy && n < 200);
        if (!i_rdy) begin
            chk("send_timeout", 32'(n), 32'd0);
            i_val = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        i_val = 1'b0;
        if (chk_wait) begin
            chk("accept_wait_cycles", 32'(n), m_pending ? 32'd2 : 32'd1);
        end
        q.push_back('{dat: d, eop: 1'b0});
        m_crc  = ref_crc(m_crc, d);
        m_cnt++;
        closes = e || (LEN_EN && m_cnt == TB_MAXLEN);
        if (closes) begin
            if (!e) m_err = 1'b1;
            q.push_back('{dat: m_crc, eop: 1'b1});
            m_crc = TB_INIT;
            m_cnt = 0;
        end
        m_pending = closes;
    endtask

    initial begin
        o_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pop on every output transfer, and check hold-while-stalled.
    initial begin
        logic        stall;
        logic [31:0] h_dat;
        logic        h_eop;
        exp_t        e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_val", {31'd0, o_val}, 32'd1);
                    chk("hold_dat", o_dat, h_dat);
                    chk("hold_eop", {31'd0, o_eop}, {31'd0, h_eop});
                end
                if (o_val && o_rdy) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", o_dat, 32'hxxxxxxxx);
                    end else begin
                        e = q.pop_front();
                        chk("out_dat", o_dat, e.dat);
                        chk("out_eop", {31'd0, o_eop}, {31'd0, e.eop});
                    end
                end
                stall = o_val && !o_rdy;
                h_dat = o_dat;
                h_eop = o_eop;
            end
        end
    end

    initial begin
        int len;
        int wait_n;
        reset = 1'b0;
        i_dat = 32'h0;
        i_eop = 1'b0;
        i_val = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_val", {31'd0, o_val}, 32'd0);
        chk("rst_o_dat", o_dat, 32'd0);
        chk("rst_o_eop", {31'd0, o_eop}, 32'd0);
        chk("rst_o_err", {31'd0, o_err}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_i_rdy", {31'd0, i_rdy}, 32'd1);

        // Single-word frame: CRC follows next cycle, input blocked meanwhile.
        send_word(32'h00000027, 1'b1, 1'b1);
        @(negedge clk);
        chk("crc_cycle_i_rdy", {31'd0, i_rdy}, 32'd0);
        @(posedge clk);
        #1;
        m_pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Register H2D FIS followed back-to-back by a second frame.
        send_word(32'h00EC8027, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) send_word(32'h0, k == 3, 1'b1);
        send_word(32'hA5A5_0001, 1'b0, 1'b1);
        send_word(32'h5A5A_0002, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        m_pending = 1'b0;

        // Over-length frame: 6 words with eop on the last.
        for (int k = 1; k <= 6; k++) send_word(32'h1000_0000 + 32'(k), k == 6, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        m_pending = 1'b0;
        chk("len_o_err", {31'd0, o_err}, {31'd0, LEN_EN});

        // Random-length frames under random downstream backpressure.
        rdy_rand = 1'b1;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 64);
            for (int w = 0; w < len; w++) send_word($urandom, w == len - 1, 1'b0);
        end
        rdy_rand = 1'b0;
        wait_n = 0;
        while (q.size() != 0 && wait_n < 2000) begin
            @(posedge clk);
            wait_n++;
        end
        chk("drain_random", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
        m_pending = 1'b0;

        // Reset in the middle of dword 3 of an 8-dword frame.
        send_word(32'hCAFE_0001, 1'b0, 1'b0);
        send_word(32'hCAFE_0002, 1'b0, 1'b0);
        i_dat = 32'hCAFE_0003;
        i_eop = 1'b0;
        i_val = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_o_val", {31'd0, o_val}, 32'd0);
        chk("async_rst_o_err", {31'd0, o_err}, 32'd0);
        i_val = 1'b0;
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h0000_1111, 1'b0, 1'b0);
        send_word(32'h0000_2222, 1'b0, 1'b0);
        send_word(32'h0000_3333, 1'b1, 1'b0);

        wait_n = 0;
        while (q.size() != 0 && wait_n < 200) begin
            @(posedge clk);
            wait_n++;
        end
        repeat (2) @(posedge clk);
        chk("drain_final", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sata_fis_crc_inserter.md
Name: sata_fis_crc_inserter

Overview:
- Single-clock, transmit-side block that feeds the FIS stream toward the link layer.
- Accepts FIS dwords with an end-of-frame flag and computes the SATA CRC-32 over each frame.
- Appends the CRC dword after the last data dword and forwards the result through a registered output stage.
- Forms the generating end of the FIS path whose receive end checks and strips the CRC.

Parameters:
MAXLEN, 2048, maximum data dwords per FIS (excluding CRC); range 1..2048
CRC_INIT, 32'h52325032, CRC register seed at start of each frame

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-low
i_dat  input  32  FIS data dword
i_eop  input  1  marks last data dword of frame
i_val  input  1  input word valid
i_rdy  output  1  input ready
o_dat  output  32  output dword (data or CRC)
o_eop  output  1  marks CRC dword (last of frame)
o_val  output  1  output valid
o_rdy  input  1  downstream ready
o_err  output  1  sticky length-violation flag

Behaviour:
- Handshake on both sides: transfer when val & rdy. o_val/o_dat/o_eop hold until o_rdy.
- Reset (reset=0, async): o_val=0, o_eop=0, o_dat=0, o_err=0, crc=CRC_INIT, cnt=0, state=DATA.
- ld = ~o_val | o_rdy (output register may load this cycle).
- States:
  - DATA: i_rdy = ld.
    - On accept: o_dat<=i_dat, o_eop<=0, o_val<=1, crc<=crc32(crc,i_dat), cnt<=cnt+1.
    - If i_eop was accepted: go to CRC.
    - If ld and no accept: o_val<=0.
  - CRC: i_rdy=0.
    - When ld: o_dat<=crc (value after last data dword), o_eop<=1, o_val<=1, crc<=CRC_INIT, cnt<=0, go to DATA.
- CRC function:
  - Polynomial 0x04C11DB7, MSB-first over the full dword, no reflection, no final XOR.
  - Combinational, one dword per cycle.
- Latency and throughput:
  - Latency input->output: 1 cycle.
  - Throughput: 1 dword/cycle within a frame; exactly one input bubble per frame (the CRC cycle).
- Backpressure: o_rdy=0 stalls everything; crc and cnt change only on accepted words.
- Frames are back-to-back; no idle is required between the CRC of one frame and the first dword of the next.
- A frame of 1 dword (i_eop on the first word) is legal and produces 2 output dwords.
- Reset mid-frame discards the partial frame; no CRC is emitted for it.
- cnt width: $clog2(MAXLEN+1); cnt never exceeds MAXLEN.

Optional Feature:
- Macro SATA_FIS_LEN_CHECK_EN.
- Defined:
  - When an accepted dword brings cnt to MAXLEN without i_eop, it is treated as last: go to CRC and set o_err<=1 (sticky until reset).
  - Upstream remainder words are then taken as a new frame.
- Undefined:
  - No length check; cnt logic is removed; o_err is tied 0.
  - Frames longer than MAXLEN pass with a correct CRC over all words.

Decomposition:
- Package sata_fis_pkg:
  - SATA_CRC_POLY, SATA_CRC_INIT constants
  - function automatic sata_crc32_dword(crc, dat)
  - typedef enum logic {ST_DATA, ST_CRC} fis_tx_state_t
  - SATA_FIS_MAXLEN = 2048
- Sub-module sata_fis_crc32: combinational dword CRC step wrapping the package function, reused by the receive-side checker.

Test Plan:
- Single-word frame: i_dat=32'h00000027, i_eop=1, o_rdy=1 -> next cycle o_dat=32'h00000027, o_eop=0; following cycle o_dat=sata_crc32_dword(32'h52325032, 32'h00000027), o_eop=1; i_rdy=0 during the CRC cycle.
- 5-dword Register H2D FIS (0x00EC8027, 0, 0, 0, 0) streamed continuously -> 6 output dwords; CRC equals golden model; next frame accepted the cycle after CRC handoff with crc reseeded to CRC_INIT.
- Random o_rdy (50%) on 100 frames of random length 1..64 -> output sequence equals data+CRC model; no drop or duplicate; o_val/o_dat stable while o_rdy=0.
- reset asserted in the middle of dword 3 of 8 -> o_val=0 immediately (async); after release, a new frame produces a CRC seeded from CRC_INIT.
- With SATA_FIS_LEN_CHECK_EN and MAXLEN=4, send 6 dwords with i_eop on dword 6 -> CRC emitted after dword 4 and o_err=1; dwords 5-6 form a second frame with its own CRC.
- Without the macro, same stimulus -> one 7-dword output frame, o_err stays 0.
